// File: rtl/db9md_scan_if.sv
// db9md_scan_if
//   Pad-side bus of the DB9 Mega Drive scanner.
//   joy_in     6  pad lines, active-low: [0]Up [1]Down [2]Left [3]Right [4]TL [5]TR
//   joy_mdsel  1  pad select (TH)
//   joy_split  1  port select: 0 = player 1, 1 = player 2
//   joystick1  16 player 1 button word, active-high
//   joystick2  16 player 2 button word, active-high
//   slave  : the scanner (drives select lines and button words)
//   master : the pad / system side (drives joy_in)
interface db9md_scan_if;
    logic [5:0]  joy_in;
    logic        joy_mdsel;
    logic        joy_split;
    logic [15:0] joystick1;
    logic [15:0] joystick2;

    modport master (
        output joy_in,
        input  joy_mdsel,
        input  joy_split,
        input  joystick1,
        input  joystick2
    );

    modport slave (
        input  joy_in,
        output joy_mdsel,
        output joy_split,
        output joystick1,
        output joystick2
    );
endinterface

// File: rtl/db9md_scan.sv
// db9md_scan
//   Scans one or two Mega Drive / Atari-style pads on the shared DB9 bus and
//   latches one complete button word per player once per scan frame.
//   clk    : system clock
//   reset  : synchronous, active-high
//   bus    : db9md_scan_if.slave (joy_in in; joy_mdsel, joy_split,
//            joystick1, joystick2 out)
//   Button word: [0]R [1]L [2]D [3]U [4]B [5]C [6]A [7]Start [8]Mode [9]X
//                [10]Y [11]Z, [15:12]=0
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_P1    | scanning player 1 (split=0), phases S0..S7
//   ST_P2    | scanning player 2 (split=1), phases S0..S7
//   ST_IDLE  | split=0, mdsel=1 for IDLE_CYC so 6-button pads time out
module db9md_scan #(
    parameter int PHASE_CYC = 480,
    parameter int IDLE_CYC  = 96000
) (
    input  logic         clk,
    input  logic         reset,
    db9md_scan_if.slave  bus
);

    localparam int MAXC = (IDLE_CYC > PHASE_CYC) ? IDLE_CYC : PHASE_CYC;
    localparam int CW   = $clog2(MAXC);

    typedef enum logic [1:0] {
        ST_P1   = 2'd0,
        ST_P2   = 2'd1,
        ST_IDLE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mdsel_q, mdsel_d;
    logic            split_q, split_d;
    logic [5:0]      sync1_q, sync1_d;
    logic [5:0]      sync2_q, sync2_d;
    logic [5:0]      base_q, base_d;       // {C,B,U,D,L,R}
    logic            md_det_q, md_det_d;
    logic [1:0]      start_a_q, start_a_d; // {Start,A}
    logic            six_det_q, six_det_d;
    logic [3:0]      ext_q, ext_d;         // {Z,Y,X,Mode}
    logic [11:0]     joy1_q, joy1_d;
    logic [11:0]     joy2_q, joy2_d;

    logic [5:0]      pressed;
    logic            phase_end;
    logic            idle_end;
    logic [11:0]     word;

    always_comb begin
        pressed   = ~sync2_q;
        phase_end = (cnt_q == CW'(PHASE_CYC - 1));
        idle_end  = (cnt_q == CW'(IDLE_CYC - 1));

        // Pad-type masking: Atari/SMS pads report no A/Start, 3-button pads
        // report no Mode/X/Y/Z.
        word = {(md_det_q && six_det_q) ? ext_q : 4'h0,
                md_det_q ? start_a_q : 2'b00,
                base_q};

        sync1_d   = bus.joy_in;
        sync2_d   = sync1_q;
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q + CW'(1);
        mdsel_d   = mdsel_q;
        split_d   = split_q;
        base_d    = base_q;
        md_det_d  = md_det_q;
        start_a_d = start_a_q;
        six_det_d = six_det_q;
        ext_d     = ext_q;
        joy1_d    = joy1_q;
        joy2_d    = joy2_q;

        unique case (state_q)
            ST_P1, ST_P2: begin
                if (phase_end) begin
                    cnt_d = '0;
                    unique case (phase_q)
                        3'd0: base_d    = {pressed[5], pressed[4], pressed[0],
                                           pressed[1], pressed[2], pressed[3]};
                        3'd1: begin
                            md_det_d  = pressed[2] & pressed[3];
                            start_a_d = {pressed[5], pressed[4]};
                        end
                        3'd5: six_det_d = &pressed[3:0];
                        3'd6: ext_d     = {pressed[0], pressed[1],
                                           pressed[2], pressed[3]};
                        default: ;
                    endcase

                    if (phase_q == 3'd7) begin
                        phase_d = 3'd0;
                        mdsel_d = 1'b1;
                        if (state_q == ST_P1) begin
                            joy1_d  = word;
                            state_d = ST_P2;
                            split_d = 1'b1;
                        end else begin
                            joy2_d  = word;
                            state_d = ST_IDLE;
                            split_d = 1'b0;
                        end
                    end else begin
                        phase_d = phase_q + 3'd1;
                        // Next phase is even (mdsel high) exactly when this one is odd.
                        mdsel_d = phase_q[0];
                    end
                end
            end
            ST_IDLE: begin
                if (idle_end) begin
                    cnt_d   = '0;
                    state_d = ST_P1;
                    phase_d = 3'd0;
                    mdsel_d = 1'b1;
                    split_d = 1'b0;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_P1;
                phase_d = 3'd0;
                mdsel_d = 1'b1;
                split_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_P1;
            phase_q   <= 3'd0;
            cnt_q     <= '0;
            mdsel_q   <= 1'b1;
            split_q   <= 1'b0;
            sync1_q   <= 6'h3F;
            sync2_q   <= 6'h3F;
            base_q    <= 6'h00;
            md_det_q  <= 1'b0;
            start_a_q <= 2'b00;
            six_det_q <= 1'b0;
            ext_q     <= 4'h0;
            joy1_q    <= 12'h000;
            joy2_q    <= 12'h000;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            mdsel_q   <= mdsel_d;
            split_q   <= split_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            base_q    <= base_d;
            md_det_q  <= md_det_d;
            start_a_q <= start_a_d;
            six_det_q <= six_det_d;
            ext_q     <= ext_d;
            joy1_q    <= joy1_d;
            joy2_q    <= joy2_d;
        end
    end

    assign bus.joy_mdsel = mdsel_q;
    assign bus.joy_split = split_q;
    assign bus.joystick1 = {4'h0, joy1_q};
    assign bus.joystick2 = {4'h0, joy2_q};

endmodule

// File: tb/tb_db9md_scan.sv
// tb_db9md_scan
//   Drives modelled pads (none / Atari / 3-button / 6-button) onto the DB9
//   bus, pushes the expected word per player when a pad setup is applied and
//   pops it at each player's commit point. Select lines and both outputs are
//   compared every cycle against the bench's own timing model.
module tb_db9md_scan;

    localparam int PH    = 4;
    localparam int ID    = 40;
    localparam int FRAME = 8 * PH;
    localparam int PER   = 16 * PH + ID;

    localparam int NONE  = 0;
    localparam int ATARI = 1;
    localparam int MD3   = 2;
    localparam int MD6   = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    db9md_scan_if bus();

    db9md_scan #(.PHASE_CYC(PH), .IDLE_CYC(ID)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- pad model ----------------
    int          p1_type = NONE;
    int          p2_type = NONE;
    logic [11:0] p1_btn  = '0;
    logic [11:0] p2_btn  = '0;

    int   low_cnt = 0;
    int   hi_run  = 0;
    logic prev_md = 1'b1;
    logic prev_sp = 1'b0;

    function automatic logic [5:0] pad_lines(input int typ, input logic [11:0] b,
                                             input logic th, input int lows);
        logic [5:0] hi;
        logic [5:0] lo;
        logic [5:0] ext;
        logic [5:0] r;
        hi  = ~{b[5], b[4], b[0], b[1], b[2], b[3]};
        lo  = ~{b[7], b[6], 1'b1, 1'b1, b[2], b[3]};
        ext = ~{b[5], b[4], b[8], b[9], b[10], b[11]};
        r   = 6'h3F;
        case (typ)
            ATARI: r = hi;
            MD3:   r = th ? hi : lo;
            MD6: begin
                if (th && lows == 3)       r = ext;
                else if (!th && lows == 3) r = {~b[7], ~b[6], 4'h0};
                else if (!th && lows >= 4) r = {~b[7], ~b[6], 4'hF};
                else                       r = th ? hi : lo;
            end
            default: r = 6'h3F;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] exp_word(input int typ, input logic [11:0] b);
        logic [15:0] w;
        case (typ)
            ATARI:   w = {4'h0, b & 12'h03F};
            MD3:     w = {4'h0, b & 12'h0FF};
            MD6:     w = {4'h0, b};
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    // Pad counts TH falling edges; a port switch or a long TH-high stretch resets it.
    always @(negedge clk) begin
        if (bus.joy_split !== prev_sp)               low_cnt = 0;
        else if (prev_md === 1'b1 && bus.joy_mdsel === 1'b0) low_cnt++;
        hi_run = (bus.joy_mdsel === 1'b1) ? hi_run + 1 : 0;
        if (hi_run >= 12) low_cnt = 0;
        prev_md = bus.joy_mdsel;
        prev_sp = bus.joy_split;
    end

    always_comb begin
        bus.joy_in = 6'h3F;
        if (bus.joy_split === 1'b1)
            bus.joy_in = pad_lines(p2_type, p2_btn, bus.joy_mdsel, low_cnt);
        else
            bus.joy_in = pad_lines(p1_type, p1_btn, bus.joy_mdsel, low_cnt);
    end

    // ---------------- timing model and scoreboard ----------------
    int   pos       = 0;
    logic rst_seen  = 1'b1;
    logic mon_en    = 1'b0;
    logic [15:0] q1[$];
    logic [15:0] q2[$];
    logic [15:0] exp_j1 = '0;
    logic [15:0] exp_j2 = '0;

    always @(posedge clk) begin
        rst_seen <= reset;
        if (reset) pos <= 0;
        else       pos <= (pos == PER - 1) ? 0 : pos + 1;
    end

    always @(negedge clk) begin
        logic [2:0] ph;
        logic       em;
        logic       es;
        if (mon_en) begin
            if (rst_seen) begin
                exp_j1 = '0;
                exp_j2 = '0;
            end else if (pos == FRAME) begin
                chk("sb1_depth", 16'(q1.size()), 16'd1);
                if (q1.size() > 0) exp_j1 = q1.pop_front();
            end else if (pos == 2 * FRAME) begin
                chk("sb2_depth", 16'(q2.size()), 16'd1);
                if (q2.size() > 0) exp_j2 = q2.pop_front();
            end
            ph = 3'((pos % FRAME) / PH);
            em = (pos >= 2 * FRAME) ? 1'b1 : ~ph[0];
            es = (pos >= FRAME) && (pos < 2 * FRAME);
            chk("mdsel", {15'h0, bus.joy_mdsel}, {15'h0, em});
            chk("split", {15'h0, bus.joy_split}, {15'h0, es});
            chk("joystick1", bus.joystick1, exp_j1);
            chk("joystick2", bus.joystick2, exp_j2);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_pos(input int p);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (pos != p && n < 4 * PER);
        if (pos != p) chk("wait_pos", 16'(pos), 16'(p));
    endtask

    task automatic set_cfg(input int t1, input logic [11:0] b1,
                           input int t2, input logic [11:0] b2);
        p1_type = t1;
        p1_btn  = b1;
        p2_type = t2;
        p2_btn  = b2;
        q1.push_back(exp_word(t1, b1));
        q2.push_back(exp_word(t2, b2));
    endtask

    // Garbage during idle must never reach the outputs; the real setup is
    // applied on the last idle cycle and checked at the next commits.
    task automatic run(input int t1, input logic [11:0] b1,
                       input int t2, input logic [11:0] b2, input int nper);
        for (int i = 0; i < nper; i++) begin
            wait_pos(2 * FRAME + 6);
            p1_type = int'($urandom_range(3, 0));
            p1_btn  = 12'($urandom);
            p2_type = int'($urandom_range(3, 0));
            p2_btn  = 12'($urandom);
            wait_pos(PER - 1);
            set_cfg(t1, b1, t2, b2);
        end
    endtask

    function automatic logic [11:0] legal_btn(input int typ, input logic [11:0] b);
        logic [11:0] r;
        r = b;
        if (typ == ATARI && r[0] && r[1]) r[1] = 1'b0;
        if (typ == MD3 && r[2] && r[3])   r[2] = 1'b0;
        return r;
    endfunction

    initial begin
        int          rt1;
        int          rt2;
        logic [11:0] rb1;
        logic [11:0] rb2;

        set_cfg(NONE, 12'h000, NONE, 12'h000);
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        reset  = 1'b0;

        run(MD6,   12'h2C0, NONE, 12'h000, 2);
        run(NONE,  12'h000, MD3,  12'h128, 2);
        run(ATARI, 12'h0D1, NONE, 12'h000, 2);
        run(MD3,   12'h0C3, MD6,  12'hF0F, 1);

        for (int i = 0; i < 6; i++) begin
            rt1 = int'($urandom_range(3, 0));
            rt2 = int'($urandom_range(3, 0));
            rb1 = legal_btn(rt1, 12'($urandom));
            rb2 = legal_btn(rt2, 12'($urandom));
            run(rt1, rb1, rt2, rb2, 1);
        end

        run(MD6, 12'hABC, MD3, 12'h0F4, 1);
        wait_pos(FRAME + 3 * PH + 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q1.delete();
        q2.delete();
        set_cfg(MD6, 12'hABC, MD3, 12'h0F4);

        run(ATARI, 12'h021, MD6, 12'h5A5, 1);
        wait_pos(2 * FRAME + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
